// File: rtl/alarm_pkg.sv
// Alarm trigger shared definitions: state encoding and BCD alarm-time check.
// Imported by alarm_trigger; no ports.
package alarm_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_RINGING = 2'd2;
  localparam logic [1:0] ST_SNOOZE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ARMED   = ST_ARMED,
    RINGING = ST_RINGING,
    SNOOZE  = ST_SNOOZE
  } state_t;

  // hh 00-23, mm 00-59, every nibble a decimal digit
  function automatic logic is_valid_bcd_time(
    input logic [7:0] h,
    input logic [7:0] m
  );
    return (h[3:0] <= 4'd9) && (h <= 8'h23) &&
           (m[3:0] <= 4'd9) && (m[7:4] <= 4'd5);
  endfunction

endpackage

// File: rtl/alarm_trigger_sec_tick_gen.sv
// One-second tick generator: 1-cycle tick every SYS_CLK_FREQ clocks after clr.
// Ports: clk, reset_n (async active-low), clr (sync restart), tick (out).
module sec_tick_gen #(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam logic [31:0] LAST = 32'(SYS_CLK_FREQ - 1);

  logic [31:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: stores a BCD alarm time, compares it with RTC reads and
// drives a level alarm with dismiss, snooze and ring timeout.
// Ports: clk, reset_n, time_valid, cur_hour, cur_min, alm_set, alm_hour_in,
//   alm_min_in, alm_en, dismiss, snooze -> alarm, state_o, alm_hour, alm_min.
// Build option: define ALARM_SNOOZE_EN to enable the snooze path.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ     = 100_000_000,
  parameter int unsigned SNOOZE_MIN       = 5,
  parameter int unsigned RING_TIMEOUT_SEC = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       time_valid,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic       alm_set,
  input  logic [7:0] alm_hour_in,
  input  logic [7:0] alm_min_in,
  input  logic       alm_en,
  input  logic       dismiss,
  input  logic       snooze,
  output logic       alarm,
  output logic [1:0] state_o,
  output logic [7:0] alm_hour,
  output logic [7:0] alm_min
);

  localparam logic [31:0] RING_LAST = 32'(RING_TIMEOUT_SEC - 1);

  state_t      state;
  logic        fired;
  logic [31:0] ring_cnt;
  logic        set_ok;
  logic        hit;
  logic        tick;
  logic        clr;

  assign set_ok = alm_set && is_valid_bcd_time(alm_hour_in, alm_min_in);
  assign hit    = time_valid && cur_hour == alm_hour && cur_min == alm_min;
  assign state_o = state;

`ifdef ALARM_SNOOZE_EN
  localparam logic [31:0] SNZ_LOAD = 32'(SNOOZE_MIN * 60);
  logic [31:0] snz_cnt;
  // Hold the tick counter at zero outside timed states so every entry
  // starts a fresh second; a snooze press restarts it for the snooze.
  assign clr = (state != RINGING && state != SNOOZE) ||
               (state == RINGING && snooze);
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign clr = (state != RINGING);
`endif

  sec_tick_gen #(
    .SYS_CLK_FREQ(SYS_CLK_FREQ)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clr),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      alarm    <= 1'b0;
      alm_hour <= 8'h00;
      alm_min  <= 8'h00;
      fired    <= 1'b0;
      ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= '0;
`endif
    end else begin
      // Re-arm once the RTC has left the alarm minute
      if (time_valid && !hit) begin
        fired <= 1'b0;
      end
      if (set_ok) begin
        alm_hour <= alm_hour_in;
        alm_min  <= alm_min_in;
        fired    <= 1'b0;
      end
      if (!alm_en) begin
        state <= IDLE;
        alarm <= 1'b0;
      end else if (set_ok) begin
        state <= ARMED;
        alarm <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= ARMED;
            alarm <= 1'b0;
          end
          ARMED: begin
            if (hit && !fired) begin
              state    <= RINGING;
              alarm    <= 1'b1;
              fired    <= 1'b1;
              ring_cnt <= '0;
            end
          end
          RINGING: begin
            if (dismiss) begin
              state <= ARMED;
              alarm <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            end else if (snooze) begin
              state   <= SNOOZE;
              alarm   <= 1'b0;
              snz_cnt <= SNZ_LOAD;
`endif
            end else if (tick) begin
              if (ring_cnt == RING_LAST) begin
                state <= ARMED;
                alarm <= 1'b0;
              end else begin
                ring_cnt <= ring_cnt + 32'd1;
              end
            end
          end
          SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
            if (dismiss) begin
              state <= ARMED;
              alarm <= 1'b0;
            end else if (tick) begin
              if (snz_cnt <= 32'd1) begin
                state    <= RINGING;
                alarm    <= 1'b1;
                ring_cnt <= '0;
              end else begin
                snz_cnt <= snz_cnt - 32'd1;
              end
            end
`else
            state <= ARMED;
            alarm <= 1'b0;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger with an expected-value queue.
// Works with ALARM_SNOOZE_EN defined or undefined.
module tb_alarm_trigger;

  logic       clk;
  logic       reset_n;
  logic       time_valid;
  logic [7:0] cur_hour;
  logic [7:0] cur_min;
  logic       alm_set;
  logic [7:0] alm_hour_in;
  logic [7:0] alm_min_in;
  logic       alm_en;
  logic       dismiss;
  logic       snooze;
  logic       alarm;
  logic [1:0] state_o;
  logic [7:0] alm_hour;
  logic [7:0] alm_min;

  int total = 0;
  int bad = 0;

  string      tag_q[$];
  logic [7:0] exp_q[$];

  alarm_trigger #(
    .SYS_CLK_FREQ    (100),
    .SNOOZE_MIN      (1),
    .RING_TIMEOUT_SEC(3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .time_valid (time_valid),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .alm_set    (alm_set),
    .alm_hour_in(alm_hour_in),
    .alm_min_in (alm_min_in),
    .alm_en     (alm_en),
    .dismiss    (dismiss),
    .snooze     (snooze),
    .alarm      (alarm),
    .state_o    (state_o),
    .alm_hour   (alm_hour),
    .alm_min    (alm_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string t, input logic [7:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    string      t;
    logic [7:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tv(input logic [7:0] h, input logic [7:0] m);
    time_valid = 1'b1;
    cur_hour   = h;
    cur_min    = m;
    step();
    time_valid = 1'b0;
  endtask

  task automatic set_alm(input logic [7:0] h, input logic [7:0] m);
    alm_set     = 1'b1;
    alm_hour_in = h;
    alm_min_in  = m;
    step();
    alm_set = 1'b0;
  endtask

  // Leave the alarm minute, then hit it again: alarm must rise
  task automatic ring(input string t);
    tv(8'h07, 8'h31);
    push(t, 8'd1);
    tv(8'h07, 8'h30);
    chk({7'd0, alarm});
  endtask

  task automatic chk_state(input string t, input logic [1:0] s);
    push(t, {6'd0, s});
    chk({6'd0, state_o});
  endtask

  int hi;

  initial begin
    reset_n     = 1'b0;
    time_valid  = 1'b0;
    cur_hour    = 8'h00;
    cur_min     = 8'h00;
    alm_set     = 1'b0;
    alm_hour_in = 8'h00;
    alm_min_in  = 8'h00;
    alm_en      = 1'b0;
    dismiss     = 1'b0;
    snooze      = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    push("rst_alarm", 8'd0);
    chk({7'd0, alarm});
    chk_state("rst_state", 2'd0);
    push("rst_hour", 8'h00);
    chk(alm_hour);
    push("rst_min", 8'h00);
    chk(alm_min);

    alm_en = 1'b1;
    step();
    chk_state("arm", 2'd1);

    set_alm(8'h07, 8'h30);
    push("set_hour", 8'h07);
    chk(alm_hour);
    push("set_min", 8'h30);
    chk(alm_min);

    push("no_match", 8'd0);
    tv(8'h07, 8'h29);
    chk({7'd0, alarm});
    push("match", 8'd1);
    tv(8'h07, 8'h30);
    chk({7'd0, alarm});
    chk_state("ringing", 2'd2);

    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
    push("dismiss", 8'd0);
    chk({7'd0, alarm});
    chk_state("dismiss_st", 2'd1);
    push("same_min", 8'd0);
    tv(8'h07, 8'h30);
    chk({7'd0, alarm});
    ring("rering");

    snooze = 1'b1;
    step();
    snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
    chk_state("snooze_st", 2'd3);
    push("snooze_alarm", 8'd0);
    chk({7'd0, alarm});
    hi = 0;
    repeat (5999) begin
      step();
      if (alarm) hi++;
    end
    push("snooze_quiet", 8'd0);
    chk({7'd0, hi != 0});
    step();
    push("snooze_end", 8'd1);
    chk({7'd0, alarm});
    chk_state("snooze_end_st", 2'd2);
`else
    chk_state("snooze_ign", 2'd2);
    push("snooze_ign_alarm", 8'd1);
    chk({7'd0, alarm});
`endif
    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
    chk_state("dismiss2", 2'd1);

    ring("timeout_start");
    repeat (299) step();
    push("timeout_299", 8'd1);
    chk({7'd0, alarm});
    step();
    push("timeout_300", 8'd0);
    chk({7'd0, alarm});
    chk_state("timeout_st", 2'd1);

    ring("both_start");
    dismiss = 1'b1;
    snooze  = 1'b1;
    step();
    dismiss = 1'b0;
    snooze  = 1'b0;
    chk_state("both", 2'd1);

`ifdef ALARM_SNOOZE_EN
    ring("snz_dis_start");
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk_state("snz_enter", 2'd3);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk_state("snz_again", 2'd3);
    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
    chk_state("snz_dismiss", 2'd1);
`endif

    set_alm(8'h24, 8'h00);
    push("bad_hour_h", 8'h07);
    chk(alm_hour);
    push("bad_hour_m", 8'h30);
    chk(alm_min);
    set_alm(8'h07, 8'h5A);
    push("bad_min_h", 8'h07);
    chk(alm_hour);
    push("bad_min_m", 8'h30);
    chk(alm_min);
    set_alm(8'h23, 8'h59);
    push("edge_h", 8'h23);
    chk(alm_hour);
    push("edge_m", 8'h59);
    chk(alm_min);
    set_alm(8'h07, 8'h30);

    ring("en_off_start");
    alm_en = 1'b0;
    step();
    push("en_off", 8'd0);
    chk({7'd0, alarm});
    chk_state("en_off_st", 2'd0);
    alm_en = 1'b1;
    step();
    chk_state("en_on_st", 2'd1);

    ring("rst_mid_start");
    reset_n = 1'b0;
    #1;
    push("rst_mid", 8'd0);
    chk({7'd0, alarm});
    chk_state("rst_mid_st", 2'd0);
    push("rst_mid_h", 8'h00);
    chk(alm_hour);
    reset_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
